// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between the two memory requesters and dmem_arbiter.
// Port 0 is the core load/store path; port 1 is the loader/debug path.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, gnt1, done0, done1, rdata, err
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, gnt1, done0, done1, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and IDLE->GRANT->ACCESS sequencer for a private byte-wide memory.
// One access per three cycles; gnt, done, err and rdata are all registered.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS} state_e;

    state_e        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic          pick_c;
    logic          in_range_c;
    logic [IW-1:0] idx_c;

    assign in_range_c = (addr_q < AW'(DEPTH));
    assign idx_c      = IW'(addr_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req0 || bus.req1) state_d = GRANT;
            GRANT:   state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic; the memory effect of ACCESS is registered on entry to it,
    // so a reset on that edge cancels both the write and the done pulse.
    always_comb begin
        pick_c     = 1'b0;
        last_gnt_d = last_gnt_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        mem_d      = mem_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    pick_c     = ~last_gnt_q;
                    last_gnt_d = ~last_gnt_q;
                end else begin
                    pick_c = bus.req1;
                end
                if (bus.req0 || bus.req1) begin
                    win_d   = pick_c;
                    we_d    = pick_c ? bus.we1    : bus.we0;
                    addr_d  = pick_c ? bus.addr1  : bus.addr0;
                    wdata_d = pick_c ? bus.wdata1 : bus.wdata0;
                    gnt0_d  = ~pick_c;
                    gnt1_d  = pick_c;
                end
            end
            GRANT: begin
                done0_d = ~win_q;
                done1_d = win_q;
                err_d   = ~in_range_c;
                if (we_q) begin
                    if (in_range_c) mem_d[idx_c] = wdata_q;
                end else begin
                    rdata_d = in_range_c ? mem_q[idx_c] : '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_q      <= '{default: '0};
        end else begin
            last_gnt_q <= last_gnt_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected grants/completions from a
// queue-based memory model; an independent monitor pops and compares on every gnt/done.
module tb_dmem_arbiter;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit            port;
        bit            err;
        logic [DW-1:0] rdata;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          eq[$];
    bit            gq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_rd;
    bit            ref_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual timeout required event", name);
    endtask

    // Reference: serialised accesses applied in grant order to a plain array.
    function automatic void model(input bit port, input bit we, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d);
        exp_t e;
        e.port = port;
        e.err  = (int'(a) >= int'(DEPTH));
        if (we && !e.err) ref_mem[int'(a)] = d;
        if (!we) ref_rd = e.err ? '0 : ref_mem[int'(a)];
        e.rdata = ref_rd;
        eq.push_back(e);
        gq.push_back(port);
    endfunction

    function automatic void model_reset();
        foreach (ref_mem[i]) ref_mem[i] = '0;
        ref_rd   = '0;
        ref_last = 1'b1;
        eq.delete();
        gq.delete();
    endfunction

    task automatic drive(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic issue(input bit port, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat);
        @(negedge clk);
        model(port, we, a, d);
        drive(port, we, a, d);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (port ? bus.gnt1 : bus.gnt0) begin
                lat = i;
                break;
            end
        end
        if (port) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        if (lat == 0) fail("gnt_timeout");
    endtask

    // Both ports raise req on the same edge: a genuine tie.
    task automatic issue_pair(input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit winner;
        int t0, t1;
        @(negedge clk);
        winner   = ~ref_last;
        ref_last = winner;
        if (winner) begin
            model(1'b1, we1, a1, d1); model(1'b0, we0, a0, d0);
        end else begin
            model(1'b0, we0, a0, d0); model(1'b1, we1, a1, d1);
        end
        drive(1'b0, we0, a0, d0);
        drive(1'b1, we1, a1, d1);
        t0 = 0; t1 = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (t0 == 0 && bus.gnt0) begin t0 = i; bus.req0 = 1'b0; end
            if (t1 == 0 && bus.gnt1) begin t1 = i; bus.req1 = 1'b0; end
            if (t0 != 0 && t1 != 0) break;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (t0 == 0 || t1 == 0) fail("pair_gnt_timeout");
        else begin
            check("tie_winner", (t1 < t0) ? 32'd1 : 32'd0, 32'(winner));
            check("tie_gap", (t1 > t0) ? 32'(t1 - t0) : 32'(t0 - t1), 32'd3);
        end
    endtask

    // Monitor: compares every grant and completion against the scoreboard queues.
    initial begin : monitor
        bit   pend;
        bit   pport;
        int   since;
        bit   gexp;
        exp_t e;
        pend  = 1'b0;
        pport = 1'b0;
        since = 99;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pend  = 1'b0;
                since = 99;
                check("reset_outputs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.rdata}, '0);
            end else begin
                since++;
                if (pend)
                    check("done_after_gnt", pport ? {bus.done1, bus.done0} : {bus.done0, bus.done1}, 32'd2);
                pend = 1'b0;
                if (bus.gnt0 || bus.gnt1) begin
                    check("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);
                    check("gnt_spacing", (since >= 3) ? 32'd1 : 32'd0, 32'd1);
                    since = 0;
                    if (gq.size() == 0) fail("unexpected_gnt");
                    else begin
                        gexp = gq.pop_front();
                        check("gnt_port", 32'(bus.gnt1), 32'(gexp));
                    end
                    pend  = 1'b1;
                    pport = bus.gnt1;
                end
                if (bus.done0 || bus.done1) begin
                    check("done_exclusive", 32'(bus.done0 & bus.done1), 32'd0);
                    if (eq.size() == 0) fail("unexpected_done");
                    else begin
                        e = eq.pop_front();
                        check("done_port", 32'(bus.done1), 32'(e.port));
                        check("err", 32'(bus.err), 32'(e.err));
                        check("rdata", 32'(bus.rdata), 32'(e.rdata));
                    end
                end
            end
        end
    end

    initial begin : stim
        int            lat;
        int            cnt;
        int            tprev;
        logic [AW-1:0] a;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("post_reset", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.rdata}, '0);

        // Basic write then read-back with fixed latency
        issue(1'b0, 1'b1, 8'd3, 8'h7F, lat);
        check("write_gnt_latency", 32'(lat), 32'd1);
        issue(1'b0, 1'b0, 8'd3, 8'h00, lat);

        // Alternating ties; the second tie also covers read-after-write across ports
        issue_pair(1'b0, 8'd3, 8'h00, 1'b0, 8'd7, 8'h00);
        issue_pair(1'b0, 8'd5, 8'h00, 1'b1, 8'd5, 8'h81);

        // Out-of-range accesses leave memory untouched
        issue(1'b0, 1'b1, 8'd20, 8'h55, lat);
        issue(1'b0, 1'b0, 8'd20, 8'h00, lat);
        issue(1'b0, 1'b0, 8'd4, 8'h00, lat);
        issue(1'b1, 8'd0 == 8'd0, 8'd15, 8'hA5, lat);
        issue(1'b0, 1'b0, 8'd15, 8'h00, lat);

        // req0 held high across three loads
        @(negedge clk);
        a = 8'd3;
        model(1'b0, 1'b0, a, '0);
        model(1'b0, 1'b0, a + 8'd2, '0);
        model(1'b0, 1'b0, a + 8'd12, '0);
        drive(1'b0, 1'b0, a, '0);
        cnt   = 0;
        tprev = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.gnt0) begin
                cnt++;
                if (cnt > 1) check("hold_interval", 32'(i - tprev), 32'd3);
                tprev = i;
                if (cnt == 3) begin
                    bus.req0 = 1'b0;
                    break;
                end
                bus.addr0 = (cnt == 1) ? a + 8'd2 : a + 8'd12;
            end
        end
        bus.req0 = 1'b0;
        check("hold_grants", 32'(cnt), 32'd3);

        // Reset on the access edge cancels the write and the done pulse
        issue(1'b0, 1'b1, 8'd2, 8'h33, lat);
        @(negedge clk);
        gq.push_back(1'b0);
        drive(1'b0, 1'b1, 8'd2, 8'h22);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.gnt0) begin
                lat = i;
                break;
            end
        end
        bus.req0 = 1'b0;
        if (lat == 0) fail("rst_gnt_timeout");
        rst = 1'b1;
        @(negedge clk);
        check("rst_no_done", {bus.done0, bus.done1, bus.err}, 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        rst = 1'b0;
        model_reset();
        issue(1'b0, 1'b0, 8'd2, 8'h00, lat);
        check("post_rst_gnt_latency", 32'(lat), 32'd1);
        issue_pair(1'b0, 8'd9, 8'h00, 1'b0, 8'd2, 8'h00);

        // Randomised mix of single and contended accesses
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: issue(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 21)), DW'($urandom), lat);
                1: issue(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 21)), DW'($urandom), lat);
                default: issue_pair(1'($urandom_range(0, 1)), AW'($urandom_range(0, 21)), DW'($urandom),
                                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 21)), DW'($urandom));
            endcase
        end

        for (int i = 0; i < 20 && (eq.size() != 0 || gq.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_done", 32'(eq.size()), 32'd0);
        check("drain_gnt", 32'(gq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
